// File: rtl/ps2_kbd_port.sv
// ps2_kbd_port
// Keyboard responder for the CPU I/O read space. Receives PS/2 scan-code
// frames, buffers the data bytes in a small FIFO and presents the FIFO head
// to the bus.
//
// Ports:
//   clk       system clock, all state on the rising edge
//   clrn      synchronous active-low reset
//   ps2_clk   raw PS/2 clock from the keyboard (asynchronous)
//   ps2_data  raw PS/2 data from the keyboard (asynchronous)
//   io_rdn    I/O read strobe, active low, may stay low for several cycles
//   ready     FIFO non-empty (registered)
//   key_data  FIFO head byte, 8'h00 when empty (registered)
//   overflow  sticky: a valid frame was dropped because the FIFO was full
//   frame_err one-cycle pulse on a bad start, parity or stop bit
//
// Bus handshake: an entry is offered while ready=1; it is consumed at the end
// of a read access, i.e. in the cycle where io_rdn is high and was low in the
// previous cycle. key_data therefore holds still for the whole access.
module ps2_kbd_port #(
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       io_rdn,
  output logic       ready,
  output logic [7:0] key_data,
  output logic       overflow,
  output logic       frame_err
);

  localparam int                DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Synchronisers: two flops per line, a third on the clock for edge detect.
  logic ps2c_s1_q, ps2c_s2_q, ps2c_s3_q, ps2d_s1_q, ps2d_s2_q;
  logic fall;

  state_t      state_q, state_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [9:0]  sr_q, sr_d, sr_new;
  logic [15:0] tmo_q, tmo_d;
  logic        frame_err_q, frame_err_d;
  logic        push_req;

  logic [7:0]            mem_q [DEPTH];
  logic [7:0]            mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  rdn_prev_q;
  logic                  overflow_q, overflow_d;
  logic                  ready_q, ready_d;
  logic [7:0]            key_data_q, key_data_d;
  logic                  pop, push, full;

  assign fall = ps2c_s3_q & ~ps2c_s2_q;

  // Receiver. The shift register only collects d0..d7, parity and stop, so
  // after the stop bit sr_new[7:0] is the byte, [8] parity, [9] stop.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    sr_d        = sr_q;
    tmo_d       = tmo_q;
    frame_err_d = 1'b0;
    push_req    = 1'b0;
    sr_new      = {ps2d_s2_q, sr_q[9:1]};
    case (state_q)
      IDLE: begin
        tmo_d = 16'd0;
        if (fall) begin
          if (!ps2d_s2_q) begin
            state_d  = SHIFT;
            bitcnt_d = 4'd1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (fall) begin
          tmo_d    = 16'd0;
          sr_d     = sr_new;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd10) begin
            state_d  = IDLE;
            bitcnt_d = 4'd0;
            // Odd parity: XOR over d0..d7 and the parity bit must be 1.
            if ((^sr_new[8:0]) && sr_new[9]) push_req = 1'b1;
            else                            frame_err_d = 1'b1;
          end
        end else if (tmo_q == TIMEOUT) begin
          // Keyboard went quiet mid-frame: drop it silently.
          state_d  = IDLE;
          bitcnt_d = 4'd0;
          tmo_d    = 16'd0;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO. A pop in the same cycle frees a slot, so push+pop on a full FIFO
  // is not an overflow.
  always_comb begin
    full       = (count_q == FULL);
    pop        = io_rdn & ~rdn_prev_q & (count_q != '0);
    push       = push_req & (~full | pop);
    overflow_d = overflow_q | (push_req & full & ~pop);
    wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(push);
    rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(pop);
    count_d    = count_q + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
    mem_d      = mem_q;
    if (push) mem_d[wr_ptr_q] = sr_new[7:0];
    ready_d    = (count_d != '0);
    key_data_d = 8'h00;
    if (ready_d) begin
      // The new head may be the byte being written this very cycle.
      if (push && (rd_ptr_d == wr_ptr_q)) key_data_d = sr_new[7:0];
      else                                key_data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      ps2c_s1_q   <= 1'b1;
      ps2c_s2_q   <= 1'b1;
      ps2c_s3_q   <= 1'b1;
      ps2d_s1_q   <= 1'b1;
      ps2d_s2_q   <= 1'b1;
      state_q     <= IDLE;
      bitcnt_q    <= 4'd0;
      sr_q        <= 10'd0;
      tmo_q       <= 16'd0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rdn_prev_q  <= 1'b1;
      overflow_q  <= 1'b0;
      ready_q     <= 1'b0;
      key_data_q  <= 8'h00;
    end else begin
      ps2c_s1_q   <= ps2_clk;
      ps2c_s2_q   <= ps2c_s1_q;
      ps2c_s3_q   <= ps2c_s2_q;
      ps2d_s1_q   <= ps2_data;
      ps2d_s2_q   <= ps2d_s1_q;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      sr_q        <= sr_d;
      tmo_q       <= tmo_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rdn_prev_q  <= io_rdn;
      overflow_q  <= overflow_d;
      ready_q     <= ready_d;
      key_data_q  <= key_data_d;
    end
  end

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ready     = ready_q;
  assign key_data  = key_data_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_port.sv
// Testbench for ps2_kbd_port: directed PS/2 frames and bus read strobes with
// hand-computed expected values. Inputs change on the falling clk edge and
// outputs are sampled on the falling edge.
module tb_ps2_kbd_port;

  localparam logic [15:0] TMO  = 16'd200;
  localparam int          HALF = 20;   // clk cycles per PS/2 clock half-period

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       io_rdn = 1'b1;
  logic       ready;
  logic [7:0] key_data;
  logic       overflow;
  logic       frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int err_pulses = 0;
  int long_pulses = 0;
  logic frame_err_prev = 1'b0;

  ps2_kbd_port #(.DEPTH_LOG2(3), .TIMEOUT(TMO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .io_rdn(io_rdn), .ready(ready), .key_data(key_data),
    .overflow(overflow), .frame_err(frame_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk); clrn = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
  endtask

  // frame_err pulse monitor
  always @(negedge clk) begin
    if (frame_err) err_pulses++;
    if (frame_err && frame_err_prev) long_pulses++;
    frame_err_prev = frame_err;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drivers
  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par);
    logic p;
    p = ~(^b) ^ bad_par;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic drive_bit(input logic v);
    ps2_data = v;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) drive_bit(f[i]);
  endtask

  // mode 0: plain; 1: check push latency on the stop bit (expects 8'h1C);
  // 2: end a read strobe on the same edge that pushes the byte.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int mode);
    logic [10:0] f;
    f = make_frame(b, bad_par);
    send_bits(f, 10);
    ps2_data = f[10];
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    if (mode == 2) io_rdn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (mode == 1) check("lat_ready_early", ready, 1'b0);
    if (mode == 2) io_rdn = 1'b1;
    @(negedge clk);
    if (mode == 1) begin
      check("lat_ready", ready, 1'b1);
      check("lat_key", key_data, 8'h1C);
    end
    repeat (HALF - 3) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic read_check(input logic [7:0] exp);
    @(negedge clk);
    check("rd_ready", ready, 1'b1);
    check("rd_key", key_data, exp);
    io_rdn = 1'b0;
    repeat (2) @(negedge clk);
    io_rdn = 1'b1;
    @(negedge clk);
  endtask

  int e0;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b0);
    check("rst_key", key_data, 8'h00);
    check("rst_ovf", overflow, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    clrn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 0x1C with latency check, then a 3-cycle read
    send_frame(8'h1C, 1'b0, 1);
    @(negedge clk);
    io_rdn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_key", key_data, 8'h1C);
      check("hold_ready", ready, 1'b1);
    end
    io_rdn = 1'b1;
    @(negedge clk);
    check("pop_ready", ready, 1'b0);
    check("pop_key", key_data, 8'h00);

    // 2: nine frames, no reads -> overflow, 0x09 dropped
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 0);
    @(negedge clk);
    check("ovf_set", overflow, 1'b1);
    check("ovf_count", dut.count_q, 4'd8);
    for (int i = 1; i <= 8; i++) read_check(8'(i));
    check("ovf_empty_ready", ready, 1'b0);
    check("ovf_empty_key", key_data, 8'h00);
    check("ovf_sticky", overflow, 1'b1);

    // 3: bad parity
    do_reset();
    e0 = err_pulses;
    send_frame(8'h1C, 1'b1, 0);
    repeat (3) @(negedge clk);
    check("par_err_pulses", err_pulses - e0, 1);
    check("par_err_width", long_pulses, 0);
    check("par_ready", ready, 1'b0);
    check("par_count", dut.count_q, 4'd0);

    // 4: partial frame then timeout, then 0xF0
    e0 = err_pulses;
    send_bits(make_frame(8'h33, 1'b0), 5);
    repeat (int'(TMO) + 10) @(negedge clk);
    send_frame(8'hF0, 1'b0, 0);
    @(negedge clk);
    check("tmo_count", dut.count_q, 4'd1);
    check("tmo_key", key_data, 8'hF0);
    check("tmo_no_err", err_pulses - e0, 0);
    read_check(8'hF0);

    // 5: full FIFO, read strobe aligned with push of 0xAA
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 0);
    @(negedge clk);
    check("full_count", dut.count_q, 4'd8);
    send_frame(8'hAA, 1'b0, 2);
    @(negedge clk);
    check("align_ovf", overflow, 1'b0);
    check("align_count", dut.count_q, 4'd8);
    for (int i = 1; i < 8; i++) read_check(8'h10 + 8'(i));
    read_check(8'hAA);
    check("align_empty", ready, 1'b0);

    // 6: reset mid-frame with 2 entries buffered
    do_reset();
    send_frame(8'h21, 1'b0, 0);
    send_frame(8'h22, 1'b0, 0);
    @(negedge clk);
    check("mid_pre_count", dut.count_q, 4'd2);
    send_bits(make_frame(8'h77, 1'b0), 6);
    @(negedge clk); clrn = 1'b0;
    @(negedge clk); clrn = 1'b1;
    check("mid_ready", ready, 1'b0);
    check("mid_key", key_data, 8'h00);
    check("mid_ovf", overflow, 1'b0);
    check("mid_count", dut.count_q, 4'd0);
    e0 = err_pulses;
    send_frame(8'h5A, 1'b0, 0);
    @(negedge clk);
    check("mid_after_count", dut.count_q, 4'd1);
    check("mid_after_err", err_pulses - e0, 0);
    read_check(8'h5A);
    check("mid_final_ready", ready, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
